// File: rtl/simon_sequencer_pkg.sv
// Shared definitions for the pattern-memory game round controller:
// FSM state encoding, code/level widths and a small sizing helper.
package game_defs;

  localparam int CODE_W  = 3;
  localparam int LEVEL_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_INPUT,
    S_FAIL,
    S_WIN
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/simon_sequencer_phase_timer.sv
// Loadable down-counter shared by the show, gap and input-timeout phases.
// done is high while the count sits at zero, i.e. on the last cycle of a phase.
module simon_sequencer_phase_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/simon_sequencer.sv
// Simon round controller: appends a random code each round, plays the
// sequence back, then checks button presses against it under a timeout.
module simon_sequencer
  import game_defs::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CODE_W-1:0]  rnd,
  input  logic               btn_valid,
  input  logic [CODE_W-1:0]  btn_code,
  output logic               show_valid,
  output logic [CODE_W-1:0]  show_code,
  output logic               await_input,
  output logic [LEVEL_W-1:0] level,
  output logic               game_over,
  output logic               win
);

  localparam int IDX_W = $clog2(MAX_LEN);
  // The timer is loaded with (phase length - 1), so the widest phase fits in CNT_W.
  localparam int CNT_W = $clog2(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES));

  localparam logic [CNT_W-1:0] SHOW_LOAD    = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [LEVEL_W-1:0]  idx;
  logic [IDX_W-1:0]    idx_lo;
  logic [CODE_W-1:0]   seq_buf [2**IDX_W];
  logic                last;
  logic                press_ok;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_value;
  logic                tmr_done;

  assign idx_lo   = idx[IDX_W-1:0];
  assign last     = (idx == level - LEVEL_W'(1));
  assign press_ok = btn_valid && (btn_code == seq_buf[idx_lo]);

  simon_sequencer_phase_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // NOTE: defaults assigned first so no path through this block infers a latch.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state)
      S_APPEND: begin
        tmr_load  = 1'b1;
        tmr_value = SHOW_LOAD;
      end
      S_SHOW_ON: if (tmr_done) begin
        tmr_load  = 1'b1;
        tmr_value = GAP_LOAD;
      end
      S_SHOW_GAP: if (tmr_done) begin
        tmr_load  = 1'b1;
        tmr_value = last ? TIMEOUT_LOAD : SHOW_LOAD;
      end
      S_INPUT: if (press_ok) begin
        tmr_load  = 1'b1;
        tmr_value = TIMEOUT_LOAD;
      end
      default: ;
    endcase
  end

  // NOTE: the sequence buffer is plain storage with no reset; every entry is
  // written in APPEND before any phase can read it.
  always_ff @(posedge clk) begin
    if (state == S_APPEND)
      seq_buf[level[IDX_W-1:0]] <= rnd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      level       <= '0;
      show_valid  <= 1'b0;
      show_code   <= '0;
      await_input <= 1'b0;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          level <= '0;
          state <= S_APPEND;
        end
        S_APPEND: begin
          level      <= level + LEVEL_W'(1);
          idx        <= '0;
          show_valid <= 1'b1;
          // On the first round entry 0 is being written this very cycle.
          show_code  <= (level == '0) ? rnd : seq_buf[0];
          state      <= S_SHOW_ON;
        end
        S_SHOW_ON: if (tmr_done) begin
          show_valid <= 1'b0;
          show_code  <= '0;
          state      <= S_SHOW_GAP;
        end
        S_SHOW_GAP: if (tmr_done) begin
          if (last) begin
            idx         <= '0;
            await_input <= 1'b1;
            state       <= S_INPUT;
          end else begin
            idx        <= idx + LEVEL_W'(1);
            show_valid <= 1'b1;
            show_code  <= seq_buf[idx_lo + IDX_W'(1)];
            state      <= S_SHOW_ON;
          end
        end
        S_INPUT: begin
          if (btn_valid) begin
            if (press_ok) begin
              if (last) begin
                await_input <= 1'b0;
                if (level == LEVEL_W'(MAX_LEN)) begin
                  win   <= 1'b1;
                  state <= S_WIN;
                end else begin
                  state <= S_APPEND;
                end
              end else begin
                idx <= idx + LEVEL_W'(1);
              end
            end else begin
              await_input <= 1'b0;
              game_over   <= 1'b1;
              state       <= S_FAIL;
            end
          end else if (tmr_done) begin
            await_input <= 1'b0;
            game_over   <= 1'b1;
            state       <= S_FAIL;
          end
        end
        S_FAIL, S_WIN: if (start) begin
          level     <= '0;
          game_over <= 1'b0;
          win       <= 1'b0;
          state     <= S_APPEND;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: a per-cycle vector table for the first
// rounds, then hand-written sequences for reset, win and timeout corners.
module tb_simon_sequencer;

  localparam int MAX_LEN = 4;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst, start, btn_valid;
  logic [2:0] rnd, btn_code;
  logic       show_valid, await_input, game_over, win;
  logic [2:0] show_code;
  logic [4:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] seq [8];

  typedef struct {
    logic       start;
    logic [2:0] rnd;
    logic       bv;
    logic [2:0] bc;
    logic       sv;
    logic [2:0] sc;
    logic       aw;
    logic [4:0] lv;
    logic       go;
    logic       wn;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  simon_sequencer #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rnd(rnd),
    .btn_valid(btn_valid), .btn_code(btn_code),
    .show_valid(show_valid), .show_code(show_code), .await_input(await_input),
    .level(level), .game_over(game_over), .win(win)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {show_valid, show_code, await_input, level, game_over, win};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic [2:0] r, input logic bv, input logic [2:0] bc,
                     input logic sv, input logic [2:0] sc, input logic aw, input logic [4:0] lv,
                     input logic go, input logic wn);
    vec_t v;
    v.start = s; v.rnd = r; v.bv = bv; v.bc = bc;
    v.sv = sv; v.sc = sc; v.aw = aw; v.lv = lv; v.go = go; v.wn = wn;
    vecs.push_back(v);
  endtask

  task automatic press(input logic [2:0] c);
    btn_valid = 1'b1;
    btn_code  = c;
    tick();
    btn_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait for the input phase while hammering a wrong button, checking the playback.
  task automatic show_round(input int r);
    int shown = 0;
    int bad   = 0;
    bit got   = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      btn_valid = 1'b1;
      btn_code  = seq[0] ^ 3'b111;
      tick();
      if (show_valid) begin
        if (shown / SHOW > r) bad++;
        else if (show_code !== seq[shown / SHOW]) bad++;
        shown++;
      end
      if (await_input) got = 1'b1;
    end
    btn_valid = 1'b0;
    check($sformatf("await_r%0d", r), 16'(got), 16'd1);
    check($sformatf("show_len_r%0d", r), 16'(shown), 16'((r + 1) * SHOW));
    check($sformatf("show_codes_r%0d", r), 16'(bad), 16'd0);
    check($sformatf("level_r%0d", r), 16'(level), 16'(r + 1));
    check($sformatf("no_fail_r%0d", r), 16'(game_over), 16'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rnd = '0; btn_valid = 1'b0; btn_code = '0;
    tick();
    tick();
    check("reset", 16'(outs()), 16'd0);
    rst = 1'b0;

    //   st rnd bv bc   sv sc aw lv go wn
    add(1, 5, 0, 0,   0, 0, 0, 0, 0, 0);   // start sampled -> APPEND
    add(0, 5, 0, 0,   1, 5, 0, 1, 0, 0);
    add(0, 5, 0, 0,   1, 5, 0, 1, 0, 0);
    add(0, 5, 1, 5,   1, 5, 0, 1, 0, 0);   // press during show ignored
    add(0, 5, 0, 0,   1, 5, 0, 1, 0, 0);
    add(0, 5, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 5, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 2, 1, 5,   0, 0, 1, 1, 0, 0);   // press on gap exit ignored
    add(0, 2, 1, 5,   0, 0, 0, 1, 0, 0);   // correct press -> APPEND
    add(0, 2, 0, 0,   1, 5, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 2, 0, 0, 1, 5, 0, 2, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 2, 0, 0, 0, 0, 0, 2, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 2, 0, 0, 1, 2, 0, 2, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 2, 0, 0, 0, 0, 0, 2, 0, 0);
    add(0, 2, 0, 0,   0, 0, 1, 2, 0, 0);
    add(0, 2, 1, 5,   0, 0, 1, 2, 0, 0);   // first code right
    add(0, 2, 1, 3,   0, 0, 0, 2, 1, 0);   // expected 2 -> game over
    add(0, 2, 0, 0,   0, 0, 0, 2, 1, 0);
    add(0, 2, 1, 2,   0, 0, 0, 2, 1, 0);   // press in FAIL ignored
    add(1, 7, 0, 0,   0, 0, 0, 0, 0, 0);   // restart
    add(0, 7, 0, 0,   1, 7, 0, 1, 0, 0);
    add(1, 7, 0, 0,   1, 7, 0, 1, 0, 0);   // start during show ignored
    for (int i = 0; i < 2; i++) add(0, 7, 0, 0, 1, 7, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 7, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 7, 0, 0,   0, 0, 1, 1, 0, 0);
    add(1, 7, 0, 0,   0, 0, 1, 1, 0, 0);   // start during input ignored

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; rnd = vecs[i].rnd;
      btn_valid = vecs[i].bv; btn_code = vecs[i].bc;
      tick();
      check($sformatf("vec%0d", i), 16'(outs()),
            16'({vecs[i].sv, vecs[i].sc, vecs[i].aw, vecs[i].lv, vecs[i].go, vecs[i].wn}));
    end
    start = 1'b0; btn_valid = 1'b0;

    rst = 1'b1;
    tick();
    check("rst_mid_input", 16'(outs()), 16'd0);
    rst = 1'b0;

    rnd = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    idle(3);
    check("show_before_rst", 16'(show_valid), 16'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_show", 16'(outs()), 16'd0);
    rst = 1'b0;
    press(3'd1);
    check("idle_after_rst", 16'(outs()), 16'd0);

    // Full win through MAX_LEN rounds.
    seq[0] = 3'd3; seq[1] = 3'd6; seq[2] = 3'd1; seq[3] = 3'd4; seq[4] = 3'd0;
    rnd = seq[0]; start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < MAX_LEN; r++) begin
      show_round(r);
      for (int j = 0; j <= r; j++) begin
        if (j == r) rnd = seq[r + 1];
        press(seq[j]);
        if (j < r) check($sformatf("mid_r%0d_%0d", r, j), 16'(await_input), 16'd1);
      end
    end
    check("win", 16'(outs()), 16'({1'b0, 3'd0, 1'b0, 5'd4, 1'b0, 1'b1}));
    press(3'd3);
    check("win_held", 16'(outs()), 16'({1'b0, 3'd0, 1'b0, 5'd4, 1'b0, 1'b1}));

    // New game from WIN, then the timeout corners.
    seq[0] = 3'd2; seq[1] = 3'd0; seq[2] = 3'd5;
    rnd = seq[0]; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_from_win", 16'({level, win}), 16'd0);
    show_round(0);
    rnd = seq[1];
    press(seq[0]);
    show_round(1);
    idle(TIMEOUT - 2);
    press(seq[0]);                          // 63rd input cycle
    check("press63_restart", 16'({await_input, game_over}), 16'b10);
    idle(TIMEOUT - 1);
    rnd = seq[2];
    press(seq[1]);                          // 64th cycle: press beats timeout
    check("press64_wins_race", 16'({await_input, game_over}), 16'b00);
    show_round(2);
    idle(TIMEOUT - 1);
    check("before_timeout", 16'({await_input, game_over}), 16'b10);
    tick();
    check("timeout", 16'(outs()), 16'({1'b0, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Round controller for the pattern-memory game. It consumes the free-running 3-bit output of the random generator.
- Each round it appends one random code to a sequence buffer, plays the whole sequence to the display, then checks player button entries against it.
- Sits between the random generator, the button debouncers and the LED/7-seg display driver.

Parameters:
- MAX_LEN, 16: sequence length that wins the game (2..16).
- SHOW_CYCLES, 4: clocks each code is displayed (>=1).
- GAP_CYCLES, 2: blank clocks after each displayed code (>=1).
- TIMEOUT_CYCLES, 64: clocks allowed between presses in the input phase (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or restart a game; honoured only in IDLE, FAIL or WIN.
- rnd  in  3  random generator output, sampled in APPEND.
- btn_valid  in  1  one-cycle pulse per debounced button press.
- btn_code  in  3  code of the pressed button, valid with btn_valid.
- show_valid  out  1  display the code on show_code.
- show_code  out  3  code being played back; 0 when show_valid=0.
- await_input  out  1  controller is accepting presses.
- level  out  5  current sequence length, 0..MAX_LEN.
- game_over  out  1  player failed; held until start.
- win  out  1  MAX_LEN rounds completed; held until start.

Behaviour:
- Reset: one clock, synchronous, active-high. It is fixed so and the ports are named clk and rst.
- On rst: state IDLE, idx=0, timer=0, level=0, every output 0. The sequence buffer is not cleared.
- All outputs are registered, with no combinational input-to-output path.
- IDLE: start=1 -> APPEND with level cleared.
- APPEND (1 cycle): buf[level] <= rnd; level <= level+1; idx <= 0; timer loaded -> SHOW_ON.
- SHOW_ON: show_valid=1, show_code=buf[idx] for exactly SHOW_CYCLES cycles -> SHOW_GAP.
- SHOW_GAP: outputs blank for GAP_CYCLES cycles.
  - If idx==level-1: go to INPUT with idx=0.
  - Otherwise: idx+1 and go to SHOW_ON.
- INPUT: await_input=1.
  - btn_valid with btn_code==buf[idx]: restart the timer.
    - If idx==level-1: go to WIN when level==MAX_LEN, else go to APPEND.
    - Otherwise: idx+1.
  - btn_valid with a mismatch -> FAIL.
  - TIMEOUT_CYCLES consecutive cycles without btn_valid -> FAIL.
- FAIL: game_over=1. WIN: win=1. In both, level is held; start -> APPEND with level cleared to 0 (new game).
- Timing: start sampled at edge k -> APPEND in cycle k+1 -> show_valid high from k+2.
  - For level 1, await_input rises at k+2+SHOW_CYCLES+GAP_CYCLES.
- Ignored inputs:
  - btn_valid outside INPUT, including on the exit cycle.
  - start outside IDLE/FAIL/WIN.
- rst has priority over every event, including mid-show or mid-input.
- Same-cycle btn_valid and timeout expiry: the press is evaluated and the timeout is discarded.
- The single timer counts down. It is loaded on each state entry and each accepted press.
- Counter widths cover MAX(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) with no wrap.

Decomposition:
- Shared package/header game_defs holds:
  - state encodings IDLE/APPEND/SHOW_ON/SHOW_GAP/INPUT/FAIL/WIN;
  - CODE_W=3;
  - LEVEL_W=5.
- One natural sub-module, phase_timer: a loadable down-counter with a load value input and a done flag. It is shared by show, gap and timeout.
- The sequence buffer is inline: MAX_LEN x 3 registers.

Test Plan (MAX_LEN=4, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=64):
- Reset, rnd=5, start pulse at edge k -> level=1; show_valid=1, show_code=5 for cycles k+2..k+5; blank k+6..k+7; await_input=1 from k+8.
- Press 5, then rnd=2 in APPEND -> level=2; display 5 then 2, each for 4 cycles with a 2-cycle gap; await_input returns.
- At level 2 press 5 then 3 (expected 2) -> game_over=1 the cycle after the press; await_input=0; next start -> level=1, game_over=0.
- No press for 64 cycles in INPUT -> game_over=1. A press at cycle 63 instead restarts the timer with no failure.
- Enter all codes correctly through 4 rounds -> win=1, level=4; btn_valid during SHOW phases has no effect.
- rst asserted mid SHOW_ON -> next cycle IDLE with all outputs 0; start during SHOW/INPUT is ignored.
